param_loader_bram: RTL and testbench
====================================

Name: param_loader_bram

Overview:
- Generic BRAM-to-register parameter loader; the parametrised successor of the per-layer bias/weight loaders.
- On start, it reads a runtime-selected block of `count` consecutive words from `base_addr` of an external read-only BRAM port.
- It unpacks the words into a packed output vector, tracking a configurable BRAM read latency with a tag pipeline.
- Sits between the shared parameter BRAM and each layer's MAC/activation stage.

Parameters:
- W, 8, element width in bits.
- MAX_ELEMS, 8, capacity of data_out in elements.
- ADDR_WIDTH, 11, BRAM address width.
- READ_LAT, 2, cycles from driving bram_en/bram_addr to valid bram_dout (legal range 1..4).
- CNT_W, 4, width of count; must satisfy 2^CNT_W > MAX_ELEMS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a load; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first BRAM address; sampled with start.
- count  in  CNT_W  number of elements to load; sampled with start.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_dout  in  W  BRAM read data.
- data_out  out  MAX_ELEMS*W  element i at bits [i*W +: W].
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the load completes.
- valid  out  1  level; data_out holds a complete load.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async, any state, including mid-load):
  - state=IDLE; data_out=0; bram_en=0; bram_addr=0; busy=done=valid=err=0.
  - Issue counter, capture index and tag pipeline are all cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with 1<=count<=MAX_ELEMS: latch base_addr and count; clear data_out to 0; valid<=0; busy<=1; go to ISSUE.
  - start=1 with count==0 or count>MAX_ELEMS: err pulses 1 cycle; stay IDLE; data_out and valid unchanged.
- ISSUE: one read per cycle, no bubbles.
  - Cycle k (k=0..count-1): bram_en=1, bram_addr=(base+k) mod 2^ADDR_WIDTH, so addresses wrap to 0.
  - After the last issue, go to DRAIN with bram_en<=0 and bram_addr held.
- Tag pipeline: a READ_LAT-deep shift register of {valid bit, element index}.
  - When a valid tag exits, data_out[idx*W +: W] <= bram_dout at that edge.
  - This is the only write path to data_out apart from reset and start-clear.
- DRAIN: wait until all count elements are captured, then go to DONE.
- DONE (one cycle): done=1, valid=1, busy=0; return to IDLE.
  - valid stays high until the next accepted start or reset.
- Latency:
  - Start is sampled at edge E0; the first read is driven in the cycle after E0.
  - The last element is captured at edge E0+count+READ_LAT.
  - done is high in the cycle following that edge.
  - Total: count+READ_LAT+1 cycles from start to done.
- Elements at index >= count read 0 after any accepted load.
- start while busy (ISSUE/DRAIN/DONE) is ignored; no err pulse.
- start in the same cycle done is high is ignored; it is accepted on the next cycle if still asserted.

Decomposition:
- Shared package param_pkg holds:
  - the state encoding localparams (IDLE/ISSUE/DRAIN/DONE);
  - default W/ADDR_WIDTH;
  - the per-layer base-address constants (e.g. L1 bias base 1032).
- One natural sub-module, read_tag_pipe: a READ_LAT-deep valid+index shift register with a flush-on-reset input.

Test Plan:
- Basic load: BRAM model with mem[a]=a[7:0], READ_LAT=2; start with base=1032, count=8.
  - Required: bram_addr 1032..1039 on consecutive cycles.
  - data_out = {0x0F,0x0E,...,0x08} (element 0 = 0x08).
  - done exactly 11 cycles after start; valid=1; err never high.
- Partial load: after the basic load, start with base=100, count=3.
  - Required: valid drops the cycle after start.
  - Final data_out elements 0..2 = 0x64,0x65,0x66 and elements 3..7 = 0.
  - done 6 cycles after start.
- Address wrap: base=2046, count=4.
  - Required: addresses 2046, 2047, 0, 1.
  - data_out elements = 0xFE, 0xFF, 0x00, 0x01.
- Illegal count: start with count=0, then count=9.
  - Required: err pulses 1 cycle each; bram_en stays 0; data_out and valid from the prior load unchanged.
- Busy and reset: start a count=8 load, pulse start again at cycle 3, then assert rst asynchronously at cycle 5.
  - Required: the second start has no effect.
  - On rst, all outputs go to 0 immediately; no done pulse.
  - A new start after reset completes a normal load.
- Latency sweep: repeat the basic load with READ_LAT=1 and READ_LAT=4.
  - Required: done after 10 and 13 cycles respectively; identical data_out.

Source files
------------

// File: rtl/param_pkg.sv
// Shared constants for the parameter loaders: FSM state encoding, default widths
// and the per-layer base addresses into the shared parameter BRAM.
package param_pkg;

  localparam int DEF_W          = 8;
  localparam int DEF_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int L1_WEIGHT_BASE = 0;
  localparam int L1_BIAS_BASE   = 1032;
  localparam int L2_WEIGHT_BASE = 1040;
  localparam int L2_BIAS_BASE   = 1552;

  // A load request is legal when it asks for at least one and at most max elements.
  function automatic logic count_legal(input int unsigned cnt, input int unsigned max_elems);
    return (cnt != 0) && (cnt <= max_elems);
  endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Shift register of {valid, element index} that follows each BRAM read through
// the read latency, so the returning word knows which element slot it fills.
module read_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic             vld_reg [DEPTH];
  logic [IDX_W-1:0] idx_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg[0] <= 1'b0;
      idx_reg[0] <= '0;
    end else if (flush) begin
      vld_reg[0] <= 1'b0;
      idx_reg[0] <= '0;
    end else begin
      vld_reg[0] <= in_valid;
      idx_reg[0] <= in_idx;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg[gi] <= 1'b0;
        idx_reg[gi] <= '0;
      end else if (flush) begin
        vld_reg[gi] <= 1'b0;
        idx_reg[gi] <= '0;
      end else begin
        vld_reg[gi] <= vld_reg[gi-1];
        idx_reg[gi] <= idx_reg[gi-1];
      end
    end
  end

  assign out_valid = vld_reg[DEPTH-1];
  assign out_idx   = idx_reg[DEPTH-1];

endmodule

// File: rtl/param_loader_bram.sv
// Loads `count` consecutive BRAM words starting at `base_addr` into a packed
// register vector, one read per cycle, with a tag pipeline covering read latency.
module param_loader_bram
  import param_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int MAX_ELEMS  = 8,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_LAT   = 2,
  parameter int CNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [CNT_W-1:0]       count,
  output logic                   bram_en,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  input  logic [W-1:0]           bram_dout,
  output logic [MAX_ELEMS*W-1:0] data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic                   err
);

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [CNT_W-1:0]        issue_idx_reg, issue_idx_next;
  logic                    bram_en_reg, bram_en_next;
  logic [ADDR_WIDTH-1:0]   bram_addr_reg, bram_addr_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    valid_reg, valid_next;
  logic                    err_reg, err_next;
  logic                    clear_data;
  logic                    tag_valid;
  logic [CNT_W-1:0]        tag_idx;
  logic                    last_capture;

  read_tag_pipe #(
    .DEPTH (READ_LAT),
    .IDX_W (CNT_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear_data),
    .in_valid  (bram_en_reg),
    .in_idx    (issue_idx_reg),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // Tags retire in issue order, so the final element's tag marks the end of the load.
  assign last_capture = tag_valid && (tag_idx == count_reg - CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      issue_idx_reg <= '0;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      issue_idx_reg <= issue_idx_next;
      bram_en_reg   <= bram_en_next;
      bram_addr_reg <= bram_addr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    issue_idx_next = issue_idx_reg;
    bram_en_next   = 1'b0;
    bram_addr_next = bram_addr_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    valid_next     = valid_reg;
    err_next       = 1'b0;
    clear_data     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count_legal(int'(count), MAX_ELEMS)) begin
            state_next     = ISSUE;
            count_next     = count;
            issue_idx_next = '0;
            bram_en_next   = 1'b1;
            bram_addr_next = base_addr;
            busy_next      = 1'b1;
            valid_next     = 1'b0;
            clear_data     = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue_idx_reg == count_reg - CNT_ONE) begin
          state_next = DRAIN;
        end else begin
          bram_en_next   = 1'b1;
          bram_addr_next = bram_addr_reg + ADDR_ONE;
          issue_idx_next = issue_idx_reg + CNT_ONE;
        end
      end
      DRAIN: begin
        if (last_capture) begin
          state_next = DONE;
          done_next  = 1'b1;
          valid_next = 1'b1;
          busy_next  = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_elem
    logic [W-1:0] elem_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        elem_reg <= '0;
      end else if (clear_data) begin
        elem_reg <= '0;
      end else if (tag_valid && (tag_idx == CNT_W'(gi))) begin
        elem_reg <= bram_dout;
      end
    end
    assign data_out[gi*W +: W] = elem_reg;
  end

  assign bram_en   = bram_en_reg;
  assign bram_addr = bram_addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign valid     = valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_param_loader_bram.sv
// Drives three loaders (read latency 1, 2 and 4) with shared stimulus and checks
// each against a behavioural model of the load: addresses, timing and contents.
module tb_param_loader_bram;

  localparam int W  = 8;
  localparam int ME = 8;
  localparam int AW = 11;
  localparam int CW = 4;
  localparam int NI = 3;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;

  logic          bram_en   [NI];
  logic [AW-1:0] bram_addr [NI];
  logic [W-1:0]  bram_dout [NI];
  logic [ME*W-1:0] data_out [NI];
  logic          busy  [NI];
  logic          done  [NI];
  logic          valid [NI];
  logic          err   [NI];

  logic [W-1:0]  mem [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int RL = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic [W-1:0] rd_pipe [RL];
    // Behavioural BRAM: address sampled at the edge, data appears RL cycles after it was driven.
    always @(posedge clk) begin
      rd_pipe[0] <= bram_en[gi] ? mem[bram_addr[gi]] : 8'h5A;
      for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign bram_dout[gi] = rd_pipe[RL-1];

    param_loader_bram #(
      .W(W), .MAX_ELEMS(ME), .ADDR_WIDTH(AW), .READ_LAT(RL), .CNT_W(CW)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .bram_en   (bram_en[gi]),
      .bram_addr (bram_addr[gi]),
      .bram_dout (bram_dout[gi]),
      .data_out  (data_out[gi]),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .valid     (valid[gi]),
      .err       (err[gi])
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // Expected register image: element i holds mem[(base+i) mod 2^AW] for i<cnt, zero beyond.
  function automatic logic [63:0] model_data(input int b, input int c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ME; i++)
      if (i < c) r[i*8 +: 8] = mem[(b + i) % DEPTH];
    return r;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [lat=%0d]: got %0h, expected %0h", name, lat(inst), act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      chk({name, "_ctl"}, i, 64'({bram_en[i], bram_addr[i], busy[i], done[i], valid[i], err[i]}), 64'd0);
      chk({name, "_data"}, i, data_out[i], 64'd0);
    end
  endtask

  task automatic run_load(input int b, input int c, input logic [63:0] exp);
    int done_cyc [NI];
    int done_n   [NI];
    int nadr     [NI];
    int adr_bad  [NI];
    int err_n    [NI];
    for (int i = 0; i < NI; i++) begin
      done_cyc[i] = -1; done_n[i] = 0; nadr[i] = 0; adr_bad[i] = 0; err_n[i] = 0;
    end
    $display("[TB] load base=%0d count=%0d", b, c);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); count = CW'(c);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        if (cyc == 1) begin
          chk("valid_drop", i, 64'(valid[i]), 64'd0);
          chk("busy_set", i, 64'(busy[i]), 64'd1);
        end
        if (bram_en[i] === 1'b1) begin
          if (int'(bram_addr[i]) != (b + nadr[i]) % DEPTH) adr_bad[i]++;
          nadr[i]++;
        end
        if (done[i] === 1'b1) begin
          done_n[i]++;
          if (done_cyc[i] < 0) done_cyc[i] = cyc;
        end
        if (err[i] !== 1'b0) err_n[i]++;
      end
      if (cyc < 18) @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      chk("done_cycle", i, 64'(done_cyc[i]), 64'(c + lat(i) + 1));
      chk("done_pulses", i, 64'(done_n[i]), 64'd1);
      chk("issue_count", i, 64'(nadr[i]), 64'(c));
      chk("addr_seq_errors", i, 64'(adr_bad[i]), 64'd0);
      chk("err_during_load", i, 64'(err_n[i]), 64'd0);
      chk("data_out", i, data_out[i], exp);
      chk("valid_after", i, 64'(valid[i]), 64'd1);
      chk("busy_after", i, 64'(busy[i]), 64'd0);
    end
  endtask

  task automatic run_bad(input int b, input int c, input logic [63:0] prev_exp, input logic prev_valid);
    int en_n [NI];
    for (int i = 0; i < NI; i++) en_n[i] = 0;
    $display("[TB] rejected start base=%0d count=%0d", b, c);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); count = CW'(c);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("err_pulse", i, 64'(err[i]), 64'd1);
      chk("busy_on_err", i, 64'(busy[i]), 64'd0);
    end
    for (int cyc = 2; cyc <= 6; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (cyc == 2) chk("err_one_cycle", i, 64'(err[i]), 64'd0);
        if (bram_en[i] !== 1'b0) en_n[i]++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk("bram_en_on_err", i, 64'(en_n[i]), 64'd0);
      chk("data_kept", i, data_out[i], prev_exp);
      chk("valid_kept", i, 64'(valid[i]), 64'(prev_valid));
    end
  endtask

  typedef struct {
    int          base;
    int          cnt;
    logic        bad;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        vt [5];
    logic [63:0] prev_exp;
    logic        prev_valid;
    int          stray [NI];

    vt[0] = '{1032, 8, 1'b0, 64'h0F0E0D0C0B0A0908};
    vt[1] = '{100,  3, 1'b0, 64'h0000000000666564};
    vt[2] = '{2046, 4, 1'b0, 64'h000000000100FFFE};
    vt[3] = '{7,    0, 1'b1, 64'h000000000100FFFE};
    vt[4] = '{7,    9, 1'b1, 64'h000000000100FFFE};

    for (int a = 0; a < DEPTH; a++) mem[a] = W'(a);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    prev_exp = '0;
    prev_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      if (vt[v].bad) begin
        run_bad(vt[v].base, vt[v].cnt, vt[v].exp, prev_valid);
      end else begin
        run_load(vt[v].base, vt[v].cnt, vt[v].exp);
        prev_exp = vt[v].exp;
        prev_valid = 1'b1;
      end
    end

    // Start while busy must be ignored; asynchronous reset mid-load clears everything.
    $display("[TB] busy start + async reset sequence");
    @(negedge clk);
    start = 1'b1; base_addr = AW'(768); count = CW'(8);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(5); count = CW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("busy_ignore_addr", i, 64'(bram_addr[i]), 64'd771);
      chk("busy_ignore_en", i, 64'(bram_en[i]), 64'd1);
      chk("busy_ignore_err", i, 64'(err[i]), 64'd0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) stray[i] = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        if (done[i] !== 1'b0 || bram_en[i] !== 1'b0 || valid[i] !== 1'b0) stray[i]++;
    end
    for (int i = 0; i < NI; i++) chk("quiet_after_reset", i, 64'(stray[i]), 64'd0);
    run_load(1032, 8, 64'h0F0E0D0C0B0A0908);
    prev_exp = 64'h0F0E0D0C0B0A0908;
    prev_valid = 1'b1;

    // Randomised loads against the model, with fresh memory contents.
    for (int a = 0; a < DEPTH; a++) mem[a] = W'($urandom);
    for (int n = 0; n < 24; n++) begin
      int b;
      int c;
      b = int'($urandom_range(0, DEPTH - 1));
      c = int'($urandom_range(0, 10));
      if (c >= 1 && c <= ME) begin
        prev_exp = model_data(b, c);
        run_load(b, c, prev_exp);
        prev_valid = 1'b1;
      end else begin
        run_bad(b, c, prev_exp, prev_valid);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
